instruction_scheduler: RTL and testbench

INSTRUCTION_SCHEDULER -- requirements
Module: instruction_scheduler

---
 rtl/instruction_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_instruction_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_scheduler.sv
// In-order single-issue instruction scheduler.
// Pops one instruction at a time from the instruction FIFO, checks it against
// the register scoreboard for RAW/WAW hazards, and issues it to the fast or
// slow execution unit. Completions from either unit clear scoreboard bits.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a non-empty FIFO; pops and latches the head instruction
// CHECK | latched instruction is decoded; issue, stall, drop NOP or flag illegal
module instruction_scheduler #(
  parameter int STALL_W = 8
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [15:0]        instr_in,
  input  logic               instr_empty,
  output logic               instr_read,
  input  logic               fast_busy,
  input  logic               slow_busy,
  output logic               fast_start,
  output logic               slow_start,
  output logic [15:0]        issue_instr,
  input  logic               fast_done,
  input  logic [3:0]         fast_done_reg,
  input  logic               slow_done,
  input  logic [3:0]         slow_done_reg,
  output logic [15:0]        dependency_remove,
  output logic [15:0]        pending,
  output logic               stalled,
  output logic               illegal_op,
  output logic [STALL_W-1:0] stall_count
);

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_STORE2 = 4'h1;
  localparam logic [3:0] OP_LOAD   = 4'h2;
  localparam logic [3:0] OP_ADD    = 4'h3;
  localparam logic [3:0] OP_SUB    = 4'h4;
  localparam logic [3:0] OP_MUL    = 4'h5;
  localparam logic [3:0] OP_SIN    = 4'h6;
  localparam logic [3:0] OP_NEG    = 4'h7;
  localparam logic [3:0] OP_ABS    = 4'h8;
  localparam logic [3:0] OP_MOVE   = 4'h9;
  localparam logic [3:0] OP_STORE1 = 4'hA;

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [15:0]        instr_q;
  logic [15:0]        instr_d;
  logic [15:0]        pending_q;
  logic [15:0]        pending_d;
  logic [STALL_W-1:0] stall_cnt_q;
  logic [STALL_W-1:0] stall_cnt_d;

  logic [3:0]  opcode;
  logic [3:0]  dest;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic        is_writer;
  logic        reads_src1;
  logic        reads_src2;
  logic        to_slow;
  logic        is_nop;
  logic        is_illegal;
  logic        hazard;
  logic        unit_busy;
  logic        issue;
  logic [15:0] done_clr;
  logic [15:0] issue_set;

  assign opcode = instr_q[15:12];
  assign dest   = instr_q[11:8];
  assign src1   = instr_q[7:4];
  assign src2   = instr_q[3:0];

  // Opcode decode: which register fields matter and which unit executes it.
  always_comb begin
    is_writer  = 1'b0;
    reads_src1 = 1'b0;
    reads_src2 = 1'b0;
    to_slow    = 1'b0;
    is_nop     = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_NOP: begin
        is_nop = 1'b1;
      end
      OP_STORE2, OP_STORE1: begin
        // Stores touch no tracked register.
      end
      OP_LOAD: begin
        is_writer = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        is_writer  = 1'b1;
        reads_src1 = 1'b1;
        reads_src2 = 1'b1;
      end
      OP_MUL: begin
        is_writer  = 1'b1;
        reads_src1 = 1'b1;
        reads_src2 = 1'b1;
        to_slow    = 1'b1;
      end
      OP_SIN: begin
        is_writer  = 1'b1;
        reads_src1 = 1'b1;
        to_slow    = 1'b1;
      end
      OP_NEG, OP_ABS, OP_MOVE: begin
        is_writer  = 1'b1;
        reads_src1 = 1'b1;
      end
      default: begin
        is_illegal = 1'b1;
      end
    endcase
  end

  // Hazards look only at the registered scoreboard, so a completion seen this
  // cycle cannot release a dependent instruction until the following cycle.
  always_comb begin
    hazard = (reads_src1 && pending_q[src1]) ||
             (reads_src2 && pending_q[src2]) ||
             (is_writer  && pending_q[dest]);
    unit_busy = to_slow ? slow_busy : fast_busy;
  end

  // Next-state and strobe generation.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    instr_read  = 1'b0;
    fast_start  = 1'b0;
    slow_start  = 1'b0;
    stalled     = 1'b0;
    illegal_op  = 1'b0;
    issue       = 1'b0;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      IDLE: begin
        if (!instr_empty) begin
          instr_d    = instr_in;
          instr_read = 1'b1;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        if (is_illegal) begin
          illegal_op = 1'b1;
          state_d    = IDLE;
        end else if (is_nop) begin
          state_d = IDLE;
        end else if (hazard || unit_busy) begin
          stalled = 1'b1;
          if (stall_cnt_q != {STALL_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
          end
        end else begin
          issue      = 1'b1;
          fast_start = !to_slow;
          slow_start = to_slow;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Scoreboard update: both completions clear, a new issue sets, set wins.
  always_comb begin
    done_clr  = 16'h0000;
    issue_set = 16'h0000;
    if (fast_done) begin
      done_clr = done_clr | (16'h0001 << fast_done_reg);
    end
    if (slow_done) begin
      done_clr = done_clr | (16'h0001 << slow_done_reg);
    end
    if (issue && is_writer) begin
      issue_set = 16'h0001 << dest;
    end
    pending_d = (pending_q & ~done_clr) | issue_set;
  end

  // State, latched instruction, scoreboard and stall counter registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      instr_q     <= 16'h0000;
      pending_q   <= 16'h0000;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      pending_q   <= pending_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign issue_instr       = instr_q;
  assign pending           = pending_q;
  assign stall_count       = stall_cnt_q;
  assign dependency_remove = done_clr;

endmodule

// File: tb/tb_instruction_scheduler.sv
// Directed bench for instruction_scheduler with a small FIFO model in front
// and an issue scoreboard behind: expected issues are queued when the
// instruction is pushed and compared whenever a start strobe appears.
module tb_instruction_scheduler;

  logic        clk;
  logic        n_rst;
  logic [15:0] instr_in;
  logic        instr_empty;
  logic        instr_read;
  logic        fast_busy;
  logic        slow_busy;
  logic        fast_start;
  logic        slow_start;
  logic [15:0] issue_instr;
  logic        fast_done;
  logic [3:0]  fast_done_reg;
  logic        slow_done;
  logic [3:0]  slow_done_reg;
  logic [15:0] dependency_remove;
  logic [15:0] pending;
  logic        stalled;
  logic        illegal_op;
  logic [7:0]  stall_count;

  int checks = 0;
  int errors = 0;

  logic [15:0] fifo_q[$];
  logic [16:0] sb_q[$];

  instruction_scheduler #(.STALL_W(8)) dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .instr_in          (instr_in),
    .instr_empty       (instr_empty),
    .instr_read        (instr_read),
    .fast_busy         (fast_busy),
    .slow_busy         (slow_busy),
    .fast_start        (fast_start),
    .slow_start        (slow_start),
    .issue_instr       (issue_instr),
    .fast_done         (fast_done),
    .fast_done_reg     (fast_done_reg),
    .slow_done         (slow_done),
    .slow_done_reg     (slow_done_reg),
    .dependency_remove (dependency_remove),
    .pending           (pending),
    .stalled           (stalled),
    .illegal_op        (illegal_op),
    .stall_count       (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    instr_empty = (fifo_q.size() == 0);
    instr_in    = (fifo_q.size() == 0) ? 16'h0000 : fifo_q[0];
  endtask

  task automatic push_instr(input logic [15:0] v);
    fifo_q.push_back(v);
    drive_fifo();
  endtask

  task automatic expect_issue(input logic [15:0] v, input logic slow);
    sb_q.push_back({slow, v});
  endtask

  // One clock cycle: settle, score any issue, advance, then update the FIFO.
  task automatic tick();
    logic        popped;
    logic [16:0] e;
    #1;
    if (fast_start && slow_start) chk("dual_start", 32'd1, 32'd0);
    if (instr_read && (fast_start || slow_start || stalled || illegal_op))
      chk("read_in_check", 32'd1, 32'd0);
    if (fast_start || slow_start) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_start", {30'd0, fast_start, slow_start}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("issue_instr", {16'd0, issue_instr}, {16'd0, e[15:0]});
        chk("issue_unit", {31'd0, slow_start}, {31'd0, e[16]});
      end
    end
    popped = instr_read;
    @(posedge clk);
    #1;
    if (popped && fifo_q.size() > 0) void'(fifo_q.pop_front());
    drive_fifo();
    @(negedge clk);
  endtask

  initial begin
    n_rst         = 1'b0;
    fast_busy     = 1'b0;
    slow_busy     = 1'b0;
    fast_done     = 1'b0;
    fast_done_reg = 4'h0;
    slow_done     = 1'b0;
    slow_done_reg = 4'h0;
    drive_fifo();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pending", {16'd0, pending}, 32'h0);
    chk("rst_stall_count", {24'd0, stall_count}, 32'h0);
    chk("rst_issue_instr", {16'd0, issue_instr}, 32'h0);
    chk("rst_strobes", {28'd0, fast_start, slow_start, stalled, illegal_op}, 32'h0);
    @(negedge clk);
    n_rst = 1'b1;

    // ADD r3,r1,r2 on idle units
    push_instr(16'h3312);
    expect_issue(16'h3312, 1'b0);
    #1;
    chk("add_read_c0", {31'd0, instr_read}, 32'd1);
    tick();
    #1;
    chk("add_fast_start_c1", {31'd0, fast_start}, 32'd1);
    chk("add_issue_c1", {16'd0, issue_instr}, 32'h3312);
    tick();
    chk("add_pending", {16'd0, pending}, 32'h0008);
    fast_done = 1'b1; fast_done_reg = 4'd3;
    #1;
    chk("add_dep_remove", {16'd0, dependency_remove}, 32'h0008);
    tick();
    fast_done = 1'b0;
    #1;
    chk("add_pending_clr", {16'd0, pending}, 32'h0);

    // MUL r4,r1,r2 then dependent ADD r5,r4,r1
    push_instr(16'h5412);
    push_instr(16'h3541);
    expect_issue(16'h5412, 1'b1);
    expect_issue(16'h3541, 1'b0);
    tick();
    tick();
    #1;
    chk("raw_read_add", {31'd0, instr_read}, 32'd1);
    tick();
    #1;
    chk("raw_stalled", {31'd0, stalled}, 32'd1);
    chk("raw_count0", {24'd0, stall_count}, 32'd0);
    repeat (5) tick();
    #1;
    chk("raw_count5", {24'd0, stall_count}, 32'd5);
    slow_done = 1'b1; slow_done_reg = 4'd4;
    #1;
    chk("raw_dep_remove", {16'd0, dependency_remove}, 32'h0010);
    chk("raw_no_early_issue", {31'd0, fast_start}, 32'd0);
    tick();
    slow_done = 1'b0;
    #1;
    chk("raw_issue_next", {31'd0, fast_start}, 32'd1);
    chk("raw_count6", {24'd0, stall_count}, 32'd6);
    tick();
    chk("raw_pending", {16'd0, pending}, 32'h0020);
    fast_done = 1'b1; fast_done_reg = 4'd5;
    tick();
    fast_done = 1'b0;

    // WAW: LOAD r6 then MOVE r6,r2; issue cycle also sees done on r6
    push_instr(16'h2600);
    push_instr(16'h9620);
    expect_issue(16'h2600, 1'b0);
    expect_issue(16'h9620, 1'b0);
    tick();
    tick();
    tick();
    #1;
    chk("waw_stalled", {31'd0, stalled}, 32'd1);
    tick();
    tick();
    fast_done = 1'b1; fast_done_reg = 4'd6;
    #1;
    chk("waw_dep_remove", {16'd0, dependency_remove}, 32'h0040);
    tick();
    #1;
    chk("waw_issue", {31'd0, fast_start}, 32'd1);
    chk("waw_count9", {24'd0, stall_count}, 32'd9);
    tick();
    fast_done = 1'b0;
    #1;
    chk("set_wins", {16'd0, pending}, 32'h0040);

    // NEG r7,r1 blocked by a busy fast unit
    fast_busy = 1'b1;
    push_instr(16'h7710);
    expect_issue(16'h7710, 1'b0);
    tick();
    #1;
    chk("busy_fast_stalled", {31'd0, stalled}, 32'd1);
    chk("busy_fast_nostart", {31'd0, fast_start}, 32'd0);
    tick();
    fast_busy = 1'b0;
    #1;
    chk("busy_fast_issue", {31'd0, fast_start}, 32'd1);
    chk("busy_fast_count", {24'd0, stall_count}, 32'd10);
    tick();

    // SIN r8,r3 blocked by a busy slow unit
    slow_busy = 1'b1;
    push_instr(16'h6830);
    expect_issue(16'h6830, 1'b1);
    tick();
    #1;
    chk("busy_slow_stalled", {31'd0, stalled}, 32'd1);
    tick();
    slow_busy = 1'b0;
    #1;
    chk("busy_slow_issue", {31'd0, slow_start}, 32'd1);
    chk("busy_slow_count", {24'd0, stall_count}, 32'd11);
    tick();
    chk("multi_pending", {16'd0, pending}, 32'h01C0);

    // simultaneous completions, different then same register
    fast_done = 1'b1; fast_done_reg = 4'd6;
    slow_done = 1'b1; slow_done_reg = 4'd7;
    #1;
    chk("dual_done_dep", {16'd0, dependency_remove}, 32'h00C0);
    tick();
    fast_done_reg = 4'd8;
    slow_done_reg = 4'd8;
    #1;
    chk("dual_done_pending", {16'd0, pending}, 32'h0100);
    chk("same_reg_dep", {16'd0, dependency_remove}, 32'h0100);
    tick();
    fast_done = 1'b0;
    slow_done = 1'b0;
    #1;
    chk("same_reg_pending", {16'd0, pending}, 32'h0);

    // two loads then simultaneous completion on r1 and r2
    push_instr(16'h2100);
    push_instr(16'h2200);
    expect_issue(16'h2100, 1'b0);
    expect_issue(16'h2200, 1'b0);
    repeat (4) tick();
    chk("load12_pending", {16'd0, pending}, 32'h0006);
    fast_done = 1'b1; fast_done_reg = 4'd1;
    slow_done = 1'b1; slow_done_reg = 4'd2;
    #1;
    chk("done12_dep", {16'd0, dependency_remove}, 32'h0006);
    tick();
    fast_done = 1'b0;
    slow_done = 1'b0;
    #1;
    chk("done12_pending", {16'd0, pending}, 32'h0);

    // illegal opcode, NOP, STORE1
    push_instr(16'hF123);
    tick();
    #1;
    chk("illegal_pulse", {31'd0, illegal_op}, 32'd1);
    chk("illegal_nostall", {31'd0, stalled}, 32'd0);
    tick();
    chk("illegal_one_cycle", {31'd0, illegal_op}, 32'd0);
    chk("illegal_no_read", {31'd0, instr_read}, 32'd0);
    push_instr(16'h0000);
    tick();
    #1;
    chk("nop_flags", {29'd0, illegal_op, stalled, fast_start | slow_start}, 32'd0);
    tick();
    push_instr(16'hA345);
    expect_issue(16'hA345, 1'b0);
    tick();
    tick();
    chk("store_no_pending", {16'd0, pending}, 32'h0);

    // long stall saturates, then reset mid-stall discards the instruction
    fast_busy = 1'b1;
    push_instr(16'h3312);
    tick();
    repeat (300) tick();
    #1;
    chk("sat_count", {24'd0, stall_count}, 32'd255);
    chk("sat_stalled", {31'd0, stalled}, 32'd1);
    #1;
    n_rst = 1'b0;
    #1;
    chk("rst_mid_count", {24'd0, stall_count}, 32'd0);
    chk("rst_mid_issue", {16'd0, issue_instr}, 32'h0);
    chk("rst_mid_pending", {16'd0, pending}, 32'h0);
    chk("rst_mid_strobes", {27'd0, fast_start, slow_start, stalled, illegal_op, instr_read}, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    fast_busy = 1'b0;
    repeat (5) tick();
    #1;
    chk("post_rst_no_read", {31'd0, instr_read}, 32'd0);
    chk("post_rst_count", {24'd0, stall_count}, 32'd0);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
